vga_fb_arbiter: RTL

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_fb_pkg.sv | 23 ++
 rtl/vga_fb_wrfifo.sv | 55 +++++
 rtl/vga_fb_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/vga_fb_pkg.sv
// Shared constants, types and address helper for the VGA frame-buffer arbiter.
package vga_fb_pkg;

    localparam logic [9:0] H_RES  = 10'd640;
    localparam logic [9:0] V_RES  = 10'd480;
    localparam int         ADDR_W = 19;

    typedef logic [7:0] pix_t;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_HBLANK = 2'd1,
        ST_VBLANK = 2'd2
    } state_t;

    // y*640 + x as (y<<9) + (y<<7) + x, widened first so nothing truncates.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] px, input logic [9:0] py);
        logic [ADDR_W-1:0] wy;
        wy = {9'd0, py};
        return (wy << 9) + (wy << 7) + {9'd0, px};
    endfunction

endpackage

// File: rtl/vga_fb_wrfifo.sv
// Small synchronous write-request FIFO; only instantiated when VGA_FB_WR_FIFO_EN is defined.
module vga_fb_wrfifo
    import vga_fb_pkg::*;
#(
    parameter int W     = 28,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   count;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rp];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads in the active area, writes in blanking.
// Define VGA_FB_WR_FIFO_EN to buffer write requests in a 4-entry FIFO.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int WR_VBLANK_ONLY = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [9:0]          x,
    input  logic [9:0]          y,
    input  logic                visible,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [9:0]          wr_x,
    input  logic [9:0]          wr_y,
    input  logic [DATA_W-1:0]   wr_data,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [DATA_W-1:0]   pix_data,
    output logic                pix_valid,
    output logic [7:0]          drop_cnt
);

    state_t dec;
    state_t state_q;
    logic   grant_ok;
    logic   rd_v2;
    logic   accept;
    logic   in_range;
    logic   drop_inc;
    logic   g_fire;
    logic [9:0]        g_x;
    logic [9:0]        g_y;
    logic [DATA_W-1:0] g_data;

    always_comb begin
        dec      = ST_HBLANK;
        grant_ok = 1'b0;
        if (visible) begin
            dec = ST_ACTIVE;
        end else if (y >= V_RES) begin
            dec = ST_VBLANK;
        end
        grant_ok = (dec == ST_VBLANK) || ((dec == ST_HBLANK) && (WR_VBLANK_ONLY == 0));
    end

    // state_q also marks stage 1 of the read pipeline (address issued last clk).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_VBLANK;
        end else begin
            state_q <= dec;
        end
    end

    assign in_range = (wr_x < H_RES) && (wr_y < V_RES);
    assign accept   = wr_valid && wr_ready;
    assign drop_inc = accept && !in_range;

`ifdef VGA_FB_WR_FIFO_EN
    logic                     f_full;
    logic                     f_empty;
    logic                     f_pop;
    logic [20+DATA_W-1:0]     f_head;

    assign f_pop    = !f_empty && grant_ok;
    // A full FIFO still accepts when the head leaves on the same clk.
    assign wr_ready = rst_n && (!f_full || f_pop);
    assign g_fire   = f_pop;
    assign {g_x, g_y, g_data} = f_head;

    vga_fb_wrfifo #(
        .W     (20 + DATA_W),
        .DEPTH (4)
    ) u_wrfifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept && in_range),
        .din   ({wr_x, wr_y, wr_data}),
        .pop   (f_pop),
        .dout  (f_head),
        .full  (f_full),
        .empty (f_empty)
    );
`else
    assign wr_ready = rst_n && grant_ok;
    assign g_fire   = accept && in_range;
    assign g_x      = wr_x;
    assign g_y      = wr_y;
    assign g_data   = wr_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            rd_v2     <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            drop_cnt  <= '0;
        end else begin
            rd_v2     <= (state_q == ST_ACTIVE);
            pix_valid <= rd_v2;
            pix_data  <= rd_v2 ? mem_rdata : '0;
            if (dec == ST_ACTIVE) begin
                mem_we   <= 1'b0;
                mem_addr <= pix_addr(x, y);
            end else if (g_fire) begin
                mem_we    <= 1'b1;
                mem_addr  <= pix_addr(g_x, g_y);
                mem_wdata <= g_data;
            end else begin
                mem_we <= 1'b0;
            end
            if (drop_inc && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule
